goal_detector: RTL and testbench
================================

Name: goal_detector

Overview:
- Producer side of the score-event interface: watches the ball's vertical position once per frame and emits the one-cycle `score_checker1` / `score_checker2` pulses.
- The top-level score counters consume these pulses.
- Also owns serve/restart sequencing: gates ball motion, requests ball re-centering, tracks match end.
- Sits in the 50 MHz domain beside the animation generator; its outputs feed the animation generator and the top-level score logic.

Parameters:
- Y_TOP_GOAL, 10'd8, ball_y at or below this value is a goal for player 2 (bottom bar).
- Y_BOT_GOAL, 10'd472, ball_y at or above this value is a goal for player 1 (top bar).
- HOLD_FRAMES, 60, frames the ball stays frozen after a goal.
- WIN_SCORE, 9, goals that end the match for either player.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- ball_y  in  10  ball top-edge row, stable while frame_tick is high
- start_ball  in  1  raw serve button, asynchronous level
- score_checker1  out  1  one-cycle pulse: player 1 scored
- score_checker2  out  1  one-cycle pulse: player 2 scored
- ball_run  out  1  level: ball may move
- ball_center  out  1  level: animation generator holds ball at screen center
- serve_dir  out  1  0 = serve toward top bar, 1 = toward bottom bar
- game_over  out  1  level: a player reached WIN_SCORE

Behaviour:
- Reset values (synchronous, on first clk edge with reset high):
  - state = IDLE.
  - score_checker1/2 = 0, ball_run = 0, ball_center = 1, serve_dir = 0, game_over = 0.
  - Internal counts p1_cnt, p2_cnt (4 bit) = 0; hold counter = 0; synchronizer flops = 0.
- Reset mid-operation: the same values apply from any state, including mid-pulse and mid-hold.
- start_ball path:
  - 2-flop synchronizer, then rising-edge detect, giving start_evt.
  - If k is the first edge sampling start_ball high, start_evt is high between edges k+2 and k+3.
  - The FSM acts on start_evt at edge k+3.
  - Holding the button produces only one event.
- State machine:
  - IDLE: ball_center = 1, ball_run = 0. start_evt -> PLAY.
  - PLAY: ball_center = 0, ball_run = 1. Checks run only on a clk edge where frame_tick = 1.
    - ball_y >= Y_BOT_GOAL: p1_cnt++, score_checker1 = 1 for exactly the next cycle, serve_dir <= 1, go to HOLD.
    - else ball_y <= Y_TOP_GOAL: p2_cnt++, score_checker2 = 1 for the next cycle, serve_dir <= 0, go to HOLD.
    - Player 1 check has priority; at most one pulse per frame; never both in the same cycle.
    - ball_y between the goals: stay in PLAY.
  - HOLD: ball_run = 0, ball_center = 0 (ball frozen at goal position).
    - Hold counter increments on each frame_tick.
    - After the HOLD_FRAMES-th tick: go to OVER if p1_cnt or p2_cnt == WIN_SCORE, else IDLE.
    - start_evt is ignored in HOLD.
  - OVER: game_over = 1, ball_center = 1, ball_run = 0.
    - start_evt clears p1_cnt, p2_cnt, game_over and serve_dir, then goes to IDLE. No pulse is emitted.
- Widths and ranges:
  - Counts are 4-bit and never exceed WIN_SCORE.
  - Hold counter is $clog2(HOLD_FRAMES+1) bits and is cleared on entry to HOLD.
- frame_tick outside PLAY/HOLD is ignored.
- The pulse registers always self-clear the cycle after assertion.

Decomposition:
- pong_pkg holds:
  - goal_state_t enum {IDLE, PLAY, HOLD, OVER}.
  - Shared constants SCREEN_H = 480, SCREEN_W = 640, BALL_SIZE.
  - Default goal rows derived from these constants.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge pulse, reusable for the paddle buttons.

Test Plan:
- Reset then serve: reset 2 cycles, start_ball high at edge 10 held 20 cycles -> ball_center 1 until edge 13; ball_run 1 from edge 13; exactly one PLAY entry.
- Bottom goal: in PLAY, ball_y = 472 with frame_tick -> score_checker1 high exactly 1 cycle, score_checker2 stays 0, serve_dir = 1, ball_run 0 next cycle.
- Boundaries: ball_y = 471 and 9 on ticks -> no pulse. ball_y = 8 -> score_checker2 pulse. ball_y = 472 without frame_tick -> no pulse.
- Hold timing: after a goal, issue 59 frame_ticks -> still HOLD. 60th tick -> IDLE with ball_center = 1. start_ball pressed during HOLD -> ignored.
- Match end: nine player-1 goals, then 60 ticks -> game_over = 1, exactly 9 score_checker1 pulses total. start_ball -> game_over 0, IDLE, no pulse.
- Mid-operation reset: assert reset in the same cycle as a score_checker2 pulse and during HOLD -> all outputs return to reset values next edge; counts 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong screen geometry, goal rows and the goal-detector state type.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } goal_state_t;

    localparam int SCREEN_H  = 480;
    localparam int SCREEN_W  = 640;
    localparam int BALL_SIZE = 8;

    // A goal is the ball's top edge reaching one ball-height from either screen edge.
    localparam logic [9:0] GOAL_ROW_TOP = 10'(BALL_SIZE);
    localparam logic [9:0] GOAL_ROW_BOT = 10'(SCREEN_H - BALL_SIZE);

    localparam int HOLD_FRAMES_DEF = 60;
    localparam int WIN_SCORE_DEF   = 9;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a registered
// one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchronizer chain and edge-detect register.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= din;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/goal_detector.sv
// Detects goals once per frame, emits one-cycle score pulses and sequences
// serve, post-goal hold and match end.
module goal_detector
    import pong_pkg::*;
#(
    parameter logic [9:0] Y_TOP_GOAL  = GOAL_ROW_TOP,
    parameter logic [9:0] Y_BOT_GOAL  = GOAL_ROW_BOT,
    parameter int         HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int         WIN_SCORE   = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] ball_y,
    input  logic       start_ball,
    output logic       score_checker1,
    output logic       score_checker2,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic       game_over
);

    localparam int              HW        = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [3:0]      WIN       = 4'(WIN_SCORE);

    goal_state_t   state_r, state_s;
    logic [3:0]    p1_cnt_r, p1_cnt_s;
    logic [3:0]    p2_cnt_r, p2_cnt_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic          serve_dir_r, serve_dir_s;
    logic          sc1_r, sc1_s;
    logic          sc2_r, sc2_s;
    logic          run_r, center_r, over_r;
    logic          start_evt_s;

    sync_edge u_start_sync (
        .clk   (clk),
        .reset (reset),
        .din   (start_ball),
        .pulse (start_evt_s)
    );

    // Next-state, score and hold-counter logic.
    always_comb begin
        state_s     = state_r;
        p1_cnt_s    = p1_cnt_r;
        p2_cnt_s    = p2_cnt_r;
        hold_cnt_s  = hold_cnt_r;
        serve_dir_s = serve_dir_r;
        sc1_s       = 1'b0;
        sc2_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_evt_s) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    // Bottom-row check wins so a frame can never yield two pulses.
                    if (ball_y >= Y_BOT_GOAL) begin
                        p1_cnt_s    = p1_cnt_r + 4'd1;
                        sc1_s       = 1'b1;
                        serve_dir_s = 1'b1;
                        hold_cnt_s  = '0;
                        state_s     = HOLD;
                    end else if (ball_y <= Y_TOP_GOAL) begin
                        p2_cnt_s    = p2_cnt_r + 4'd1;
                        sc2_s       = 1'b1;
                        serve_dir_s = 1'b0;
                        hold_cnt_s  = '0;
                        state_s     = HOLD;
                    end else begin
                        state_s = PLAY;
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        if ((p1_cnt_r == WIN) || (p2_cnt_r == WIN)) begin
                            state_s = OVER;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        hold_cnt_s = hold_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            OVER: begin
                if (start_evt_s) begin
                    p1_cnt_s    = 4'd0;
                    p2_cnt_s    = 4'd0;
                    serve_dir_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = OVER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and outputs; level outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            p1_cnt_r    <= 4'd0;
            p2_cnt_r    <= 4'd0;
            hold_cnt_r  <= '0;
            serve_dir_r <= 1'b0;
            sc1_r       <= 1'b0;
            sc2_r       <= 1'b0;
            run_r       <= 1'b0;
            center_r    <= 1'b1;
            over_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            p1_cnt_r    <= p1_cnt_s;
            p2_cnt_r    <= p2_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
            serve_dir_r <= serve_dir_s;
            sc1_r       <= sc1_s;
            sc2_r       <= sc2_s;
            run_r       <= (state_s == PLAY);
            center_r    <= (state_s == IDLE) || (state_s == OVER);
            over_r      <= (state_s == OVER);
        end
    end

    assign score_checker1 = sc1_r;
    assign score_checker2 = sc2_r;
    assign ball_run       = run_r;
    assign ball_center    = center_r;
    assign serve_dir      = serve_dir_r;
    assign game_over      = over_r;

endmodule

// File: tb/tb_goal_detector.sv
// Directed self-checking bench for goal_detector: serve timing, goal boundaries,
// hold length, match end and mid-operation reset.
module tb_goal_detector;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [9:0] ball_y;
    logic       start_ball;
    logic       score_checker1;
    logic       score_checker2;
    logic       ball_run;
    logic       ball_center;
    logic       serve_dir;
    logic       game_over;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int sc1_total = 0;
    int sc2_total = 0;
    int both_cnt  = 0;
    int run_rises = 0;
    logic run_prev = 1'b0;

    goal_detector dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .ball_y         (ball_y),
        .start_ball     (start_ball),
        .score_checker1 (score_checker1),
        .score_checker2 (score_checker2),
        .ball_run       (ball_run),
        .ball_center    (ball_center),
        .serve_dir      (serve_dir),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse and serve bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (score_checker1) sc1_total++;
            if (score_checker2) sc2_total++;
            if (score_checker1 && score_checker2) both_cnt++;
            if (ball_run && !run_prev) run_rises++;
        end
        run_prev = ball_run;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            miss_cnt++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [9:0] y);
        ball_y     = y;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic press_start(input int hold);
        start_ball = 1'b1;
        repeat (hold) step();
        start_ball = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_sc1"},    score_checker1, 0);
        check_val({tag, "_sc2"},    score_checker2, 0);
        check_val({tag, "_run"},    ball_run,       0);
        check_val({tag, "_center"}, ball_center,    1);
        check_val({tag, "_dir"},    serve_dir,      0);
        check_val({tag, "_over"},   game_over,      0);
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        ball_y     = 10'd240;
        start_ball = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        check_reset_vals("rst");

        // Serve: button first sampled at edge E; ball released at E+3.
        start_ball = 1'b1;
        step();
        check_val("serve_e0_center", ball_center, 1);
        step();
        check_val("serve_e1_center", ball_center, 1);
        step();
        check_val("serve_e2_center", ball_center, 1);
        check_val("serve_e2_run",    ball_run,    0);
        step();
        check_val("serve_e3_center", ball_center, 0);
        check_val("serve_e3_run",    ball_run,    1);
        repeat (16) step();
        start_ball = 1'b0;
        repeat (3) step();
        check_val("serve_one_entry", run_rises, 1);

        // Goal-row boundaries.
        frame(10'd471);
        check_val("y471_sc1", score_checker1, 0);
        check_val("y471_run", ball_run, 1);
        frame(10'd9);
        check_val("y9_sc2", score_checker2, 0);
        ball_y = 10'd472;
        step();
        check_val("y472_notick_sc1", score_checker1, 0);
        check_val("y472_notick_run", ball_run, 1);
        frame(10'd472);
        check_val("bot_goal_sc1", score_checker1, 1);
        check_val("bot_goal_sc2", score_checker2, 0);
        check_val("bot_goal_dir", serve_dir, 1);
        check_val("bot_goal_run", ball_run, 0);
        check_val("bot_goal_center", ball_center, 0);
        step();
        check_val("bot_goal_sc1_clear", score_checker1, 0);

        // Hold: button ignored, 59 ticks stay, 60th releases to IDLE.
        press_start(5);
        check_val("hold_btn_run", ball_run, 0);
        check_val("hold_btn_center", ball_center, 0);
        repeat (59) frame(10'd472);
        check_val("hold59_center", ball_center, 0);
        check_val("hold59_run", ball_run, 0);
        frame(10'd472);
        check_val("hold60_center", ball_center, 1);
        check_val("hold60_run", ball_run, 0);
        check_val("hold60_over", game_over, 0);
        check_val("hold60_sc1", score_checker1, 0);
        repeat (3) step();
        check_val("idle_no_serve", ball_run, 0);

        // Top goal for player 2.
        press_start(4);
        frame(10'd8);
        check_val("top_goal_sc2", score_checker2, 1);
        check_val("top_goal_sc1", score_checker1, 0);
        check_val("top_goal_dir", serve_dir, 0);
        repeat (60) frame(10'd240);
        check_val("top_hold_idle", ball_center, 1);

        // Player 1 reaches nine goals.
        for (int g = 0; g < 8; g++) begin
            press_start(4);
            frame(10'd500);
            repeat (60) frame(10'd240);
        end
        check_val("match_over", game_over, 1);
        check_val("match_center", ball_center, 1);
        check_val("match_run", ball_run, 0);
        check_val("match_sc1_total", sc1_total, 9);
        check_val("match_sc2_total", sc2_total, 1);
        press_start(4);
        check_val("restart_over", game_over, 0);
        check_val("restart_center", ball_center, 1);
        check_val("restart_run", ball_run, 0);
        check_val("restart_dir", serve_dir, 0);
        check_val("restart_no_pulse", sc1_total, 9);
        // Counts were cleared: one more goal must not end the match.
        press_start(4);
        frame(10'd472);
        repeat (60) frame(10'd240);
        check_val("after_clear_over", game_over, 0);

        // Reset in the same cycle as a score_checker2 pulse.
        press_start(4);
        frame(10'd3);
        check_val("pre_rst_sc2", score_checker2, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rst_pulse");

        // Reset in the middle of a hold.
        press_start(4);
        frame(10'd472);
        repeat (10) frame(10'd240);
        check_val("pre_rst_hold_dir", serve_dir, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rst_hold");

        check_val("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
